// File: rtl/rca_pkg.sv
// Shared defaults and FSM state encoding for the ripple-carry adder result checker.
package rca_pkg;

  localparam int RCA_WIDTH = 4;
  localparam int RCA_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rca_state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Reference ripple-carry adder: chain of full adders producing {carry, sum} = a + b + cin.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
  end

  assign carry = w_c[WIDTH];

endmodule

// File: rtl/rca_result_checker.sv
// Checks an adder's responses against a reference ripple-carry adder over a run of num_vec
// vectors, counting passes/fails and capturing the first failing vector.
//
// state | meaning
// IDLE  | waiting for start after reset; inputs ignored
// RUN   | accepting vectors until num_vec have been taken
// DONE  | run complete, results held until the next start
module rca_result_checker
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH,
  parameter int CNT_W = RCA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic             ff_cin,
  output logic [WIDTH-1:0] ff_sum,
  output logic             ff_carry,
  output logic             busy,
  output logic             done
);

  rca_state_t       r_state;
  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err;
  logic [WIDTH-1:0] r_ff_a;
  logic [WIDTH-1:0] r_ff_b;
  logic             r_ff_cin;
  logic [WIDTH-1:0] r_ff_sum;
  logic             r_ff_carry;

  logic [WIDTH-1:0] w_exp_sum;
  logic             w_exp_carry;
  logic             w_accept;
  logic             w_match;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_ref_adder (
    .sum   (w_exp_sum),
    .carry (w_exp_carry),
    .a     (in_a),
    .b     (in_b),
    .cin   (in_cin)
  );

  assign w_accept = (r_state == RUN) && in_valid;
  assign w_match  = ({w_exp_carry, w_exp_sum} == {in_carry, in_sum});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_remain   <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_ff_a     <= '0;
      r_ff_b     <= '0;
      r_ff_cin   <= 1'b0;
      r_ff_sum   <= '0;
      r_ff_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_remain   <= num_vec;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_err      <= 1'b0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_cin   <= 1'b0;
            r_ff_sum   <= '0;
            r_ff_carry <= 1'b0;
            r_state    <= (num_vec == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (w_match) begin
              if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
            end else begin
              if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
              // Only the first mismatch of a run is kept.
              if (!r_err) begin
                r_ff_a     <= in_a;
                r_ff_b     <= in_b;
                r_ff_cin   <= in_cin;
                r_ff_sum   <= in_sum;
                r_ff_carry <= in_carry;
              end
              r_err <= 1'b1;
            end
            r_remain <= r_remain - 1'b1;
            if (r_remain == {{(CNT_W-1){1'b0}}, 1'b1}) r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == RUN);
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
  assign err      = r_err;
  assign ff_a     = r_ff_a;
  assign ff_b     = r_ff_b;
  assign ff_cin   = r_ff_cin;
  assign ff_sum   = r_ff_sum;
  assign ff_carry = r_ff_carry;

endmodule

// File: tb/tb_rca_result_checker.sv
// Self-checking bench: directed scenarios plus random runs, compared every cycle against a
// run-level reference model using plain integer arithmetic.
module tb_rca_result_checker;
  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [C-1:0] num_vec = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, in_sum = '0;
  logic         in_cin = 1'b0, in_carry = 1'b0;
  logic         in_ready, err, ff_cin, ff_carry, busy, done;
  logic [C-1:0] pass_cnt, fail_cnt;
  logic [W-1:0] ff_a, ff_b, ff_sum;

  rca_result_checker #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_carry(in_carry),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
    .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin), .ff_sum(ff_sum), .ff_carry(ff_carry),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a run is "active" while fewer than target vectors have been taken.
  bit m_idle, m_active, m_done;
  int m_target, m_taken, m_pass, m_fail;
  bit m_err;
  int m_fa, m_fb, m_fcin, m_fsum, m_fcarry;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_active = 0; m_done = 0;
    m_target = 0; m_taken = 0; m_pass = 0; m_fail = 0; m_err = 0;
    m_fa = 0; m_fb = 0; m_fcin = 0; m_fsum = 0; m_fcarry = 0;
  endtask

  task automatic model_edge();
    int expv, gotv, cmax;
    cmax = (1 << C) - 1;
    if (!m_active && start) begin
      model_reset();
      m_idle   = 0;
      m_target = int'(num_vec);
      m_active = (m_target != 0);
      m_done   = (m_target == 0);
    end else if (m_active && in_valid) begin
      expv = int'(in_a) + int'(in_b) + int'(in_cin);
      gotv = int'(in_carry) * (1 << W) + int'(in_sum);
      if (expv == gotv) begin
        if (m_pass < cmax) m_pass++;
      end else begin
        if (m_fail < cmax) m_fail++;
        if (!m_err) begin
          m_fa = in_a; m_fb = in_b; m_fcin = in_cin; m_fsum = in_sum; m_fcarry = in_carry;
        end
        m_err = 1;
      end
      m_taken++;
      if (m_taken == m_target) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, in_ready, m_active);
    chk({tag, ".busy"},  busy,     m_active);
    chk({tag, ".done"},  done,     m_done);
    chk({tag, ".pass"},  pass_cnt, m_pass);
    chk({tag, ".fail"},  fail_cnt, m_fail);
    chk({tag, ".err"},   err,      m_err);
    chk({tag, ".ff"}, {ff_a, ff_b, ff_cin, ff_sum, ff_carry},
        {m_fa[W-1:0], m_fb[W-1:0], m_fcin[0], m_fsum[W-1:0], m_fcarry[0]});
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic vec(input bit v, input int a, input int b, input int ci,
                     input int s, input int co);
    in_valid = v; in_a = a[W-1:0]; in_b = b[W-1:0]; in_cin = ci[0];
    in_sum = s[W-1:0]; in_carry = co[0];
  endtask

  task automatic go(input int n, input string tag);
    num_vec = n[C-1:0];
    start = 1'b1;
    cyc(tag);
    start = 1'b0;
  endtask

  initial begin
    int n, a, b, ci, e, r, budget;
    model_reset();
    #2;
    check_all("por");
    cyc("rst_low");
    rst_n = 1'b1;

    // Inputs ignored after reset until start.
    vec(1, 1, 2, 0, 3, 0);
    repeat (3) cyc("idle_valid");
    chk("idle_no_ready", in_ready, 1'b0);

    // Five correct vectors.
    vec(0, 0, 0, 0, 0, 0);
    go(5, "r31_start");
    vec(1, 1, 2, 0, 3, 0);   cyc("r31_v1");
    vec(1, 5, 3, 1, 9, 0);   cyc("r31_v2");
    vec(1, 15, 15, 1, 15, 1); cyc("r31_v3");
    vec(1, 10, 5, 0, 15, 0); cyc("r31_v4");
    vec(1, 12, 3, 1, 0, 1);  cyc("r31_v5");
    vec(0, 0, 0, 0, 0, 0);
    chk("r31_pass", pass_cnt, 5);
    chk("r31_fail", fail_cnt, 0);
    chk("r31_done", done, 1'b1);
    cyc("r31_hold");

    // Two mismatches; only the first is captured.
    go(2, "r32_start");
    vec(1, 5, 3, 1, 8, 0);   cyc("r32_v1");
    vec(1, 1, 1, 0, 0, 0);   cyc("r32_v2");
    vec(0, 0, 0, 0, 0, 0);
    chk("r32_fail", fail_cnt, 2);
    chk("r32_err", err, 1'b1);
    chk("r32_ff", {ff_a, ff_b, ff_cin, ff_sum, ff_carry}, {4'd5, 4'd3, 1'b1, 4'd8, 1'b0});

    // Gapped valid, plus start pulsed mid-run (ignored).
    go(2, "r33_start");
    vec(1, 2, 2, 0, 4, 0);   cyc("r33_c1");
    vec(0, 2, 2, 0, 4, 0);   start = 1'b1; num_vec = 8'd9; cyc("r36_start_in_run");
    start = 1'b0;            cyc("r33_c3");
    vec(1, 7, 8, 1, 0, 1);   cyc("r33_c4");
    chk("r33_ready_off", in_ready, 1'b0);
    vec(1, 7, 8, 1, 0, 1);   cyc("r33_after");
    chk("r33_pass", pass_cnt, 2);
    vec(0, 0, 0, 0, 0, 0);

    // Empty run.
    go(0, "r34_start");
    chk("r34_done", done, 1'b1);
    chk("r34_pass", pass_cnt, 0);
    cyc("r34_hold");

    // Reset in the middle of a run.
    go(5, "r35_start");
    vec(1, 3, 4, 0, 7, 0);   cyc("r35_v1");
    vec(1, 3, 4, 1, 7, 0);   cyc("r35_v2");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("r35_async");
    vec(0, 0, 0, 0, 0, 0);
    cyc("r35_low");
    rst_n = 1'b1;
    cyc("r35_idle");
    go(1, "r35_restart");
    vec(1, 9, 9, 0, 2, 1);   cyc("r35_v");
    vec(0, 0, 0, 0, 0, 0);
    chk("r35_pass", pass_cnt, 1);

    // Random runs with random valid gaps and corrupted responses.
    for (int run = 0; run < 25; run++) begin
      n = $urandom_range(0, 12);
      go(n, "rnd_start");
      budget = 4 * n + 10;
      while (budget > 0 && m_active) begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15); ci = $urandom_range(0, 1);
        e = a + b + ci;
        r = ($urandom_range(0, 9) < 3) ? (e ^ $urandom_range(1, 31)) : e;
        vec($urandom_range(0, 3) != 0, a, b, ci, r & 15, (r >> 4) & 1);
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1; num_vec = $urandom_range(0, 255);
        end
        cyc("rnd");
        start = 1'b0;
        budget--;
      end
      chk("rnd_timeout", m_active, 1'b0);
      vec(0, 0, 0, 0, 0, 0);
      cyc("rnd_end");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
